// File: rtl/feedback_receiver_pkg.sv
// Shared definitions for the UART feedback/script receiver: channel codes,
// feedback bit positions, script FSM encoding and default timing parameters.
package feedback_receiver_pkg;

    localparam logic [1:0] CH_FEEDBACK = 2'b01;
    localparam logic [1:0] CH_SCRIPT   = 2'b10;

    localparam int BIT_FRONT      = 2;
    localparam int BIT_HAND       = 3;
    localparam int BIT_PROCESSING = 4;
    localparam int BIT_MACHINE    = 5;

    localparam int DEF_STALE_CYCLES       = 153600;
    localparam int DEF_SCRIPT_IDLE_CYCLES = 2400;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } script_state_t;

    // Flags packed as {machine, processing, hand, front}
    function automatic logic [3:0] fb_flags(input logic [7:0] b);
        return {b[BIT_MACHINE], b[BIT_PROCESSING], b[BIT_HAND], b[BIT_FRONT]};
    endfunction

endpackage

// File: rtl/rx_valid_edge.sv
// data_valid rising-edge detector with byte capture; emits a one-cycle
// registered accept pulse alongside the captured byte.
module rx_valid_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_valid,
    input  logic [7:0] data_receive,
    output logic       accept,
    output logic [7:0] rx_byte
);

    logic prev;
    logic armed;
    logic rise;

    // armed stays low until data_valid has been seen low, so a level that is
    // already high coming out of reset is not mistaken for a new byte
    assign rise = data_valid && !prev && armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= 1'b0;
            armed   <= !data_valid;
            accept  <= 1'b0;
            rx_byte <= 8'h00;
        end else begin
            prev   <= data_valid;
            accept <= rise;
            if (!data_valid) armed   <= 1'b1;
            if (rise)        rx_byte <= data_receive;
        end
    end

endmodule

// File: rtl/feedback_receiver.sv
// UART byte receiver: decodes feedback flag frames, tracks feedback staleness,
// frames script loads by inter-byte idle time and counts rejected bytes.
module feedback_receiver
    import feedback_receiver_pkg::*;
#(
    parameter int STALE_CYCLES       = DEF_STALE_CYCLES,
    parameter int SCRIPT_IDLE_CYCLES = DEF_SCRIPT_IDLE_CYCLES
) (
    input  logic       uart_clk,
    input  logic       rst_n,
    input  logic       data_valid,
    input  logic [7:0] data_receive,
    output logic       sig_front,
    output logic       sig_hand,
    output logic       sig_processing,
    output logic       sig_machine,
    output logic       fb_update,
    output logic       fb_stale,
    output logic       script_active,
    output logic       script_done,
    output logic [7:0] script_len,
    output logic [7:0] err_count
);

    localparam int SW = $clog2(STALE_CYCLES + 1);
    localparam int IW = $clog2(SCRIPT_IDLE_CYCLES + 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(SCRIPT_IDLE_CYCLES - 1);

    logic          acc;
    logic [7:0]    rx_byte;
    logic          is_fb, is_script, is_err;
    logic [3:0]    new_flags, held_flags;
    logic [SW-1:0] stale_cnt, stale_nxt;
    logic [IW-1:0] idle_cnt;
    script_state_t state;

    rx_valid_edge u_edge (
        .clk          (uart_clk),
        .rst_n        (rst_n),
        .data_valid   (data_valid),
        .data_receive (data_receive),
        .accept       (acc),
        .rx_byte      (rx_byte)
    );

    always_comb begin
        is_fb      = acc && (rx_byte[1:0] == CH_FEEDBACK) && (rx_byte[7:6] == 2'b00);
        is_script  = acc && (rx_byte[1:0] == CH_SCRIPT);
        is_err     = acc && !is_fb && !is_script;
        new_flags  = fb_flags(rx_byte);
        held_flags = {sig_machine, sig_processing, sig_hand, sig_front};
        if (is_fb)                        stale_nxt = '0;
        else if (stale_cnt == STALE_MAX)  stale_nxt = stale_cnt;
        else                              stale_nxt = stale_cnt + SW'(1);
    end

    // The stale counter comes out of reset saturated: no frame has been seen yet
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            {sig_machine, sig_processing, sig_hand, sig_front} <= 4'b0000;
            fb_update     <= 1'b0;
            fb_stale      <= 1'b1;
            stale_cnt     <= STALE_MAX;
            err_count     <= 8'd0;
            state         <= S_IDLE;
            idle_cnt      <= '0;
            script_active <= 1'b0;
            script_done   <= 1'b0;
            script_len    <= 8'd0;
        end else begin
            fb_update <= is_fb && (new_flags != held_flags);
            if (is_fb) {sig_machine, sig_processing, sig_hand, sig_front} <= new_flags;
            stale_cnt <= stale_nxt;
            fb_stale  <= (stale_nxt == STALE_MAX);
            if (is_err && err_count != 8'hFF) err_count <= err_count + 8'd1;

            script_done <= 1'b0;
            if (state == S_IDLE) begin
                if (is_script) begin
                    state         <= S_LOAD;
                    script_active <= 1'b1;
                    script_len    <= 8'd1;
                    idle_cnt      <= '0;
                end
            end else begin
                // a byte on the timeout cycle keeps the load open
                if (is_script) begin
                    if (script_len != 8'hFF) script_len <= script_len + 8'd1;
                    idle_cnt <= '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state         <= S_IDLE;
                    script_active <= 1'b0;
                    script_done   <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_feedback_receiver.sv
// Self-checking bench for feedback_receiver: per-cycle reference model plus
// table-driven vectors and hand-written multi-cycle corner sequences.
module tb_feedback_receiver;

    logic       uart_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data_receive = 8'h00;
    logic       sig_front, sig_hand, sig_processing, sig_machine;
    logic       fb_update, fb_stale, script_active, script_done;
    logic [7:0] script_len, err_count;

    feedback_receiver #(.STALE_CYCLES(16), .SCRIPT_IDLE_CYCLES(8)) dut (
        .uart_clk       (uart_clk),
        .rst_n          (rst_n),
        .data_valid     (data_valid),
        .data_receive   (data_receive),
        .sig_front      (sig_front),
        .sig_hand       (sig_hand),
        .sig_processing (sig_processing),
        .sig_machine    (sig_machine),
        .fb_update      (fb_update),
        .fb_stale       (fb_stale),
        .script_active  (script_active),
        .script_done    (script_done),
        .script_len     (script_len),
        .err_count      (err_count)
    );

    always #5 uart_clk = ~uart_clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: timestamps of last frame/script byte instead of counters
    int         cyc = 0;
    logic [3:0] m_flags = 4'b0;
    int         m_err = 0, m_len = 0;
    bit         m_active = 0, m_fb_seen = 0;
    int         m_last_fb = 0, m_last_sc = 0;
    bit         m_pend = 0, m_prev = 0, m_seen_low = 1;
    logic [7:0] m_pend_b = 8'h00;
    bit         e_upd = 0, e_done = 0;

    int upd_cnt = 0, done_cnt = 0, done_cyc = 0, sent_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input logic dv, input logic [7:0] d, input logic rst);
        bit sc_now;
        cyc++;
        e_upd = 0; e_done = 0; sc_now = 0;
        if (!rst) begin
            m_flags = 4'b0; m_err = 0; m_len = 0; m_active = 0; m_fb_seen = 0;
            m_pend = 0; m_prev = 0; m_seen_low = !dv;
            return;
        end
        if (m_pend) begin
            if (m_pend_b[1:0] == 2'b01 && m_pend_b[7:6] == 2'b00) begin
                logic [3:0] nf;
                nf = {m_pend_b[5], m_pend_b[4], m_pend_b[3], m_pend_b[2]};
                e_upd = (nf != m_flags);
                m_flags = nf; m_last_fb = cyc; m_fb_seen = 1;
            end else if (m_pend_b[1:0] == 2'b10) begin
                sc_now = 1;
                if (!m_active) begin m_active = 1; m_len = 1; end
                else if (m_len < 255) m_len++;
                m_last_sc = cyc;
            end else if (m_err < 255) m_err++;
        end
        if (m_active && !sc_now && (cyc - m_last_sc) >= 8) begin
            m_active = 0; e_done = 1;
        end
        m_pend   = dv && !m_prev && m_seen_low;
        m_pend_b = d;
        m_prev   = dv;
        if (!dv) m_seen_low = 1;
    endtask

    task automatic tick(input logic dv, input logic [7:0] d, input logic rst);
        logic [23:0] exp_v, act_v;
        bit stale;
        @(negedge uart_clk);
        data_valid = dv; data_receive = d; rst_n = rst;
        @(posedge uart_clk);
        model_step(dv, d, rst);
        #1;
        stale = !m_fb_seen || ((cyc - m_last_fb) >= 16);
        exp_v = {m_flags, e_upd, stale, m_active, e_done, 8'(m_len), 8'(m_err)};
        act_v = {sig_machine, sig_processing, sig_hand, sig_front, fb_update, fb_stale,
                 script_active, script_done, script_len, err_count};
        n_chk++;
        if (act_v !== exp_v) begin
            n_err++;
            if (n_err < 40) $display("FAIL cycle_model: got %h expected %h (cycle %0d)", act_v, exp_v, cyc);
        end
        upd_cnt += int'(fb_update);
        if (script_done) begin done_cnt++; done_cyc = cyc; end
    endtask

    task automatic send(input logic [7:0] d, input int hold, input int gap);
        for (int i = 0; i < hold; i++) begin
            tick(1'b1, d, 1'b1);
            if (i == 0) sent_cyc = cyc;
        end
        for (int i = 0; i < gap; i++) tick(1'b0, d, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         hold;
        int         gap;
        logic [3:0] exp_flags;   // {machine, processing, hand, front}
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h00, 1, 3, 4'b0101, 1};
        vecs[1] = '{8'h03, 2, 3, 4'b0101, 2};
        vecs[2] = '{8'h45, 3, 3, 4'b0101, 3};
        vecs[3] = '{8'h2D, 1, 3, 4'b1011, 3};
        vecs[4] = '{8'h3F, 1, 3, 4'b1011, 4};
        vecs[5] = '{8'h01, 4, 3, 4'b0000, 4};
        vecs[6] = '{8'hC1, 1, 3, 4'b0000, 5};
        vecs[7] = '{8'h3D, 1, 3, 4'b1111, 5};

        // Reset state
        repeat (3) tick(1'b0, 8'h00, 1'b0);
        chk("rst_stale", int'(fb_stale), 1);
        chk("rst_flags", int'({sig_machine, sig_processing, sig_hand, sig_front}), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_len", int'(script_len), 0);
        chk("rst_active", int'(script_active), 0);

        // Held data_valid yields one accept
        upd_cnt = 0;
        send(8'h15, 5, 4);
        chk("first_upd_pulses", upd_cnt, 1);
        chk("first_flags", int'({sig_machine, sig_processing, sig_hand, sig_front}), 4'b0101);
        chk("first_stale", int'(fb_stale), 0);
        chk("first_err", int'(err_count), 0);

        // Identical frame, then starve feedback until stale
        upd_cnt = 0;
        send(8'h15, 2, 20);
        chk("repeat_upd_pulses", upd_cnt, 0);
        chk("stale_set", int'(fb_stale), 1);
        chk("stale_flags", int'({sig_machine, sig_processing, sig_hand, sig_front}), 4'b0101);

        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].hold, vecs[i].gap);
            chk($sformatf("vec%0d_flags", i),
                int'({sig_machine, sig_processing, sig_hand, sig_front}), int'(vecs[i].exp_flags));
            chk($sformatf("vec%0d_err", i), int'(err_count), vecs[i].exp_err);
        end

        // err_count saturation
        for (int i = 0; i < 300; i++) send(8'h00, 1, 1);
        chk("err_sat", int'(err_count), 255);
        send(8'hFF, 1, 3);
        chk("err_sat_hold", int'(err_count), 255);

        // Five script bytes spaced 4 cycles, then idle timeout
        done_cnt = 0;
        for (int i = 0; i < 5; i++) send(8'h02, 1, 3);
        chk("load_active", int'(script_active), 1);
        chk("load_len", int'(script_len), 5);
        chk("load_no_early_done", done_cnt, 0);
        repeat (12) tick(1'b0, 8'h00, 1'b1);
        chk("load_done_pulses", done_cnt, 1);
        chk("load_done_delay", done_cyc - (sent_cyc + 1), 8);
        chk("load_len_hold", int'(script_len), 5);
        chk("load_idle", int'(script_active), 0);

        // Byte on the timeout cycle keeps the load open
        done_cnt = 0;
        send(8'h02, 1, 7);
        send(8'h02, 1, 3);
        chk("collide_no_done", done_cnt, 0);
        chk("collide_len", int'(script_len), 2);
        chk("collide_active", int'(script_active), 1);
        repeat (10) tick(1'b0, 8'h00, 1'b1);
        chk("collide_done_later", done_cnt, 1);

        // Reset mid-load aborts silently
        send(8'h02, 1, 2);
        done_cnt = 0;
        repeat (2) tick(1'b0, 8'h00, 1'b0);
        repeat (12) tick(1'b0, 8'h00, 1'b1);
        chk("abort_active", int'(script_active), 0);
        chk("abort_len", int'(script_len), 0);
        chk("abort_no_done", done_cnt, 0);

        // data_valid high through reset release is not an edge
        repeat (2) tick(1'b1, 8'h00, 1'b0);
        repeat (3) tick(1'b1, 8'h00, 1'b1);
        chk("held_valid_no_accept", int'(err_count), 0);
        tick(1'b0, 8'h00, 1'b1);
        send(8'h00, 1, 3);
        chk("after_drop_accept", int'(err_count), 1);

        // Randomized traffic checked cycle-by-cycle against the model
        for (int i = 0; i < 3000; i++) begin
            logic       dv, rst;
            logic [7:0] d;
            dv  = ($urandom_range(0, 9) < 4);
            d   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[7:6] = 2'b00;
            if ($urandom_range(0, 2) == 0) d[1:0] = 2'b10;
            rst = ($urandom_range(0, 599) != 0);
            tick(dv, d, rst);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/feedback_receiver.md
FEEDBACK_RECEIVER -- requirements
Module: feedback_receiver

Interface
REQ-001 Parameter STALE_CYCLES, default 153600: uart_clk cycles without an accepted feedback frame before fb_stale asserts.
REQ-002 Parameter SCRIPT_IDLE_CYCLES, default 2400: uart_clk cycles without a script byte before a script load is declared complete.
REQ-003 uart_clk  in  1  single clock, 16x baud UART clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 data_valid  in  1  UART received-byte valid; may stay high for several cycles per byte.
REQ-006 data_receive  in  8  UART received byte; sampled only on the data_valid rising edge.
REQ-007 sig_front, sig_hand, sig_processing, sig_machine  out  1 each  latest decoded feedback flags.
REQ-008 fb_update  out  1  one-cycle pulse when an accepted feedback frame changes any flag.
REQ-009 fb_stale  out  1  high while no feedback frame has been accepted within STALE_CYCLES.
REQ-010 script_active  out  1  high while a script load is in progress.
REQ-011 script_done  out  1  one-cycle pulse at script load completion.
REQ-012 script_len  out  8  byte count of the current/last script load, saturating at 255.
REQ-013 err_count  out  8  count of rejected bytes, saturating at 255.

Function
REQ-014 A byte SHALL be accepted once per 0->1 transition of data_valid (registered previous value); a held-high data_valid SHALL NOT produce further accepts.
REQ-015 Channel field data_receive[1:0]: 2'b01 feedback, 2'b10 script byte; 2'b00 and 2'b11 SHALL be rejected.
REQ-016 Feedback frame: bit2 front, bit3 hand, bit4 processing, bit5 machine; bits[7:6] nonzero SHALL cause rejection with flags unchanged.
REQ-017 Accept edge detected in cycle N SHALL update flags, fb_update, counters and FSM in cycle N+1 (one-cycle latency, all outputs registered).
REQ-018 fb_update SHALL NOT pulse for an accepted frame identical to the held flags.
REQ-019 Stale counter SHALL clear on every accepted feedback frame, increment otherwise, saturate at STALE_CYCLES; fb_stale = (counter == STALE_CYCLES); flags SHALL retain last values while stale.
REQ-020 Script FSM states IDLE, LOAD; IDLE + script byte -> LOAD with script_len=1, idle counter=0.
REQ-021 LOAD + script byte -> script_len saturating +1, idle counter=0; LOAD with idle counter reaching SCRIPT_IDLE_CYCLES-1 -> IDLE with script_done pulse.
REQ-022 Script byte in the same cycle the idle timeout would fire: byte wins, FSM stays LOAD, no script_done.
REQ-023 script_len SHALL hold its final value in IDLE until the next load starts.
REQ-024 Feedback frames SHALL be decoded normally during LOAD and SHALL NOT reset the idle counter.
REQ-025 Each rejected byte SHALL increment err_count (saturating at 255, no wrap); rejection SHALL NOT affect flags, stale counter or FSM.

Reset
REQ-026 While rst_n=0 at a clock edge: all flags, fb_update, script_active, script_done, script_len, err_count = 0; fb_stale = 1; FSM = IDLE; counters cleared; edge-detect register = 0.
REQ-027 Reset during LOAD SHALL abort the load with no script_done pulse.
REQ-028 data_valid already high when rst_n releases SHALL be treated as a rising edge only after it first drops low.

Structure
REQ-029 Shared package SHALL hold channel codes (CH_FEEDBACK, CH_SCRIPT), feedback bit positions, FSM state encoding and default parameter values.
REQ-030 Sub-module rx_valid_edge SHALL implement the data_valid rising-edge detector with the byte capture register.

Verification (bench uses STALE_CYCLES=16, SCRIPT_IDLE_CYCLES=8)
REQ-031 Reset then byte 8'h15 with data_valid held 5 cycles -> fb_stale 1->0, front=1, processing=1, hand=machine=0, fb_update one cycle, one accept only.
REQ-032 Feedback 8'h15 repeated -> no fb_update; no further feedback for 16 cycles -> fb_stale=1, flags still 1/0/1/0.
REQ-033 Bytes 8'h00, 8'h03, 8'h45 -> err_count=3, flags unchanged; 300 bad bytes -> err_count=255.
REQ-034 Five script bytes 8'h02 spaced 4 cycles, then idle -> script_active high, script_len=5, script_done pulse exactly 8 cycles after last byte, script_len stays 5.
REQ-035 Script byte landing on the timeout cycle -> no script_done, script_len +1; rst_n=0 mid-LOAD -> script_active=0, script_len=0, no script_done.
